// File: rtl/cbus_axi_bridge_pkg.sv
// Shared types for the CBus-to-AXI3 bridge: request/response structs,
// AXI burst encodings and the bridge state enum.
package cbus_axi_bridge_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int LEN_W  = 4;
  localparam int ID_W   = 4;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    AW,
    W,
    B
  } bridge_state_t;

  // Arbitrated cache-side request; data/strobe carry the current write beat.
  typedef struct packed {
    logic              valid;
    logic              is_write;
    logic [2:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  len;
    logic [1:0]        burst;
  } cbus_req_t;

  // Cache-side response: ready per beat, last on completion.
  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;

  // Everything the master drives onto the AXI3 interconnect.
  typedef struct packed {
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              rready;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [LEN_W-1:0]  awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic [ID_W-1:0]   wid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              bready;
  } axi_req_t;

  // Everything the interconnect returns to the master.
  typedef struct packed {
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              awready;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
  } axi_resp_t;

endpackage

// File: rtl/cbus_axi_bridge.sv
// CBus to AXI3 master bridge. Handles one transaction at a time: address
// phase, data beats passed straight through, and for writes a wait on the
// B channel before the requester sees completion.
module cbus_axi_bridge
  import cbus_axi_bridge_pkg::*;
#(
  parameter int AXI_ID    = 0,
  parameter int MAX_BEATS = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp,
  output axi_req_t   axi_req,
  input  axi_resp_t  axi_resp
);

  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  bridge_state_t     state;
  bridge_state_t     next_state;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;

  logic accept;
  logic cnt_inc;
  logic last_beat;

  // Error responses have no path back to the cache; completion proceeds anyway.
  logic unused_resp;
  assign unused_resp = ^{axi_resp.rresp, axi_resp.bresp};

  assign last_beat = (cnt_q == CNT_W'(len_q));

  // State, beat counter and the latched address-phase fields. Direction is
  // held by the state itself, so is_write needs no separate register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        cnt_q   <= '0;
        addr_q  <= creq.addr;
        len_q   <= creq.len;
        size_q  <= creq.size;
        burst_q <= creq.burst;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Next-state and all outputs; read data and write handshakes are forwarded
  // combinationally so each beat costs no extra cycle.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    cnt_inc    = 1'b0;
    cresp      = '0;
    axi_req    = '0;

    axi_req.arid    = ID_W'(AXI_ID);
    axi_req.araddr  = addr_q;
    axi_req.arlen   = len_q;
    axi_req.arsize  = size_q;
    axi_req.arburst = burst_q;
    axi_req.awid    = ID_W'(AXI_ID);
    axi_req.awaddr  = addr_q;
    axi_req.awlen   = len_q;
    axi_req.awsize  = size_q;
    axi_req.awburst = burst_q;
    axi_req.wid     = ID_W'(AXI_ID);
    axi_req.wdata   = creq.data;
    axi_req.wstrb   = creq.strobe;

    case (state)
      IDLE: begin
        if (creq.valid) begin
          accept     = 1'b1;
          next_state = creq.is_write ? AW : AR;
        end
      end
      AR: begin
        axi_req.arvalid = 1'b1;
        if (axi_resp.arready) begin
          next_state = R;
        end
      end
      R: begin
        axi_req.rready = 1'b1;
        if (axi_resp.rvalid) begin
          cresp.ready = 1'b1;
          cresp.data  = axi_resp.rdata;
          cresp.last  = axi_resp.rlast;
          if (axi_resp.rlast) begin
            next_state = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      AW: begin
        axi_req.awvalid = 1'b1;
        if (axi_resp.awready) begin
          next_state = W;
        end
      end
      W: begin
        axi_req.wvalid = 1'b1;
        axi_req.wlast  = last_beat;
        if (axi_resp.wready) begin
          if (last_beat) begin
            next_state = B;
          end else begin
            cresp.ready = 1'b1;
            cnt_inc     = 1'b1;
          end
        end
      end
      B: begin
        axi_req.bready = 1'b1;
        if (axi_resp.bvalid) begin
          cresp.ready = 1'b1;
          cresp.last  = 1'b1;
          next_state  = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cbus_axi_bridge.sv
// Directed bench for cbus_axi_bridge: a table of read/write transactions
// played against a scripted AXI slave, plus hand-written reset and
// back-to-back sequences.
module tb_cbus_axi_bridge;
  import cbus_axi_bridge_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  axi_req_t   axi_req;
  axi_resp_t  axi_resp;

  int assertCount = 0;
  int failCount   = 0;

  // One transaction: stimulus plus the hand-computed pulse count.
  // ready_mask bit k is rvalid/wready in the k-th data cycle (1 beyond bit 7).
  typedef struct packed {
    logic             is_write;
    logic [31:0]      addr;
    logic [3:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       strobe;
    logic [7:0]       hs_delay;
    logic [7:0]       ready_mask;
    logic [7:0]       b_delay;
    logic [3:0][31:0] beat_data;
    logic [7:0]       exp_pulses;
  } vec_t;

  vec_t vecs[6];

  cbus_axi_bridge #(.AXI_ID(0), .MAX_BEATS(16)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .creq     (creq),
    .cresp    (cresp),
    .axi_req  (axi_req),
    .axi_resp (axi_resp)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case something stalls outside the bounded loops.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input logic is_write, input logic [31:0] addr,
                                 input logic [3:0] len, input logic [3:0] strobe,
                                 input logic [7:0] hs_delay, input logic [7:0] ready_mask,
                                 input logic [7:0] b_delay, input logic [31:0] d0,
                                 input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [31:0] d3, input logic [7:0] exp_pulses);
    vec_t v;
    v.is_write     = is_write;
    v.addr         = addr;
    v.len          = len;
    v.size         = 3'd2;
    v.burst        = AXI_BURST_INCR;
    v.strobe       = strobe;
    v.hs_delay     = hs_delay;
    v.ready_mask   = ready_mask;
    v.b_delay      = b_delay;
    v.beat_data[0] = d0;
    v.beat_data[1] = d1;
    v.beat_data[2] = d2;
    v.beat_data[3] = d3;
    v.exp_pulses   = exp_pulses;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays one transaction. Called 1 ns after a rising edge with the DUT in
  // IDLE; returns 1 ns after the edge that brings it back to IDLE, leaving
  // creq.valid high so the caller decides whether to chain another request.
  task automatic applyStimulus(input vec_t v);
    logic done;
    logic rdy;
    int   beat;
    int   pulses;

    creq.valid    = 1'b1;
    creq.is_write = v.is_write;
    creq.addr     = v.addr;
    creq.len      = v.len;
    creq.size     = v.size;
    creq.burst    = v.burst;
    creq.strobe   = v.strobe;
    creq.data     = v.beat_data[0];
    #3;
    checkOutput("idle arvalid", 32'(axi_req.arvalid), 32'd0);
    checkOutput("idle awvalid", 32'(axi_req.awvalid), 32'd0);
    checkOutput("idle cresp.ready", 32'(cresp.ready), 32'd0);
    tick();

    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      rdy = (k >= int'(v.hs_delay));
      if (v.is_write) axi_resp.awready = rdy;
      else            axi_resp.arready = rdy;
      #3;
      if (v.is_write) begin
        checkOutput("awvalid", 32'(axi_req.awvalid), 32'd1);
        checkOutput("wvalid before aw", 32'(axi_req.wvalid), 32'd0);
      end else begin
        checkOutput("arvalid", 32'(axi_req.arvalid), 32'd1);
      end
      if (rdy) begin
        done = 1'b1;
        if (v.is_write) begin
          checkOutput("awaddr", axi_req.awaddr, v.addr);
          checkOutput("awlen", 32'(axi_req.awlen), 32'(v.len));
        end else begin
          checkOutput("araddr", axi_req.araddr, v.addr);
          checkOutput("arlen", 32'(axi_req.arlen), 32'(v.len));
          checkOutput("arsize", 32'(axi_req.arsize), 32'(v.size));
        end
      end
      tick();
    end
    axi_resp.arready = 1'b0;
    axi_resp.awready = 1'b0;
    if (!done) checkOutput("addr phase timeout", 32'd0, 32'd1);

    beat   = 0;
    pulses = 0;
    done   = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      rdy = (k < 8) ? v.ready_mask[k[2:0]] : 1'b1;
      if (v.is_write) begin
        axi_resp.wready = rdy;
        creq.data       = v.beat_data[beat];
      end else begin
        axi_resp.rvalid = rdy;
        axi_resp.rdata  = v.beat_data[beat];
        axi_resp.rlast  = rdy && (beat == int'(v.len));
      end
      #3;
      if (cresp.ready) pulses++;
      if (v.is_write) begin
        if (k == 0) checkOutput("awvalid dropped", 32'(axi_req.awvalid), 32'd0);
        checkOutput("wvalid", 32'(axi_req.wvalid), 32'd1);
        checkOutput("wdata", axi_req.wdata, v.beat_data[beat]);
        checkOutput("wstrb", 32'(axi_req.wstrb), 32'(v.strobe));
        checkOutput("wlast", 32'(axi_req.wlast), 32'(beat == int'(v.len)));
        checkOutput("w cresp.ready", 32'(cresp.ready), 32'(rdy && (beat != int'(v.len))));
        checkOutput("w cresp.last", 32'(cresp.last), 32'd0);
      end else begin
        if (k == 0) checkOutput("arvalid dropped", 32'(axi_req.arvalid), 32'd0);
        checkOutput("rready", 32'(axi_req.rready), 32'd1);
        checkOutput("r cresp.ready", 32'(cresp.ready), 32'(rdy));
        if (rdy) begin
          checkOutput("r cresp.data", cresp.data, v.beat_data[beat]);
          checkOutput("r cresp.last", 32'(cresp.last), 32'(beat == int'(v.len)));
        end
      end
      if (rdy) begin
        if (beat == int'(v.len)) done = 1'b1;
        else beat++;
      end
      tick();
    end
    axi_resp.rvalid = 1'b0;
    axi_resp.rlast  = 1'b0;
    axi_resp.wready = 1'b0;
    if (!done) checkOutput("data phase timeout", 32'd0, 32'd1);

    if (v.is_write) begin
      done = 1'b0;
      for (int k = 0; k < 50 && !done; k++) begin
        rdy = (k >= int'(v.b_delay));
        axi_resp.bvalid = rdy;
        #3;
        if (cresp.ready) pulses++;
        checkOutput("bready", 32'(axi_req.bready), 32'd1);
        checkOutput("b cresp.ready", 32'(cresp.ready), 32'(rdy));
        checkOutput("b cresp.last", 32'(cresp.last), 32'(rdy));
        if (rdy) done = 1'b1;
        tick();
      end
      axi_resp.bvalid = 1'b0;
      if (!done) checkOutput("b phase timeout", 32'd0, 32'd1);
    end

    checkOutput("cresp pulse count", 32'(pulses), 32'(v.exp_pulses));
  endtask

  initial begin
    vecs[0] = mkVec(1'b0, 32'h1fc0_0000, 4'd0, 4'hf, 8'd2, 8'h01, 8'd0,
                    32'hdead_beef, 32'h0, 32'h0, 32'h0, 8'd1);
    vecs[1] = mkVec(1'b0, 32'h8000_0040, 4'd3, 4'hf, 8'd0, 8'h2d, 8'd0,
                    32'ha0a0_0001, 32'ha0a0_0002, 32'ha0a0_0003, 32'ha0a0_0004, 8'd4);
    vecs[2] = mkVec(1'b1, 32'h8000_1000, 4'd3, 4'hf, 8'd0, 8'hff, 8'd3,
                    32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044, 8'd4);
    vecs[3] = mkVec(1'b1, 32'h8000_2004, 4'd0, 4'h3, 8'd5, 8'hff, 8'd1,
                    32'h0000_55aa, 32'h0, 32'h0, 32'h0, 8'd1);
    vecs[4] = mkVec(1'b0, 32'h8000_3000, 4'd1, 4'hf, 8'd1, 8'h03, 8'd0,
                    32'hc0ff_ee00, 32'hc0ff_ee01, 32'h0, 32'h0, 8'd2);
    vecs[5] = mkVec(1'b1, 32'h8000_4000, 4'd1, 4'hc, 8'd0, 8'h05, 8'd0,
                    32'h1234_5678, 32'h9abc_def0, 32'h0, 32'h0, 8'd2);

    resetn   = 1'b0;
    creq     = '0;
    axi_resp = '0;
    #2;
    checkOutput("reset cresp.ready", 32'(cresp.ready), 32'd0);
    checkOutput("reset cresp.last", 32'(cresp.last), 32'd0);
    checkOutput("reset cresp.data", cresp.data, 32'd0);
    checkOutput("reset arvalid", 32'(axi_req.arvalid), 32'd0);
    checkOutput("reset awvalid", 32'(axi_req.awvalid), 32'd0);
    checkOutput("reset wvalid", 32'(axi_req.wvalid), 32'd0);
    checkOutput("reset rready", 32'(axi_req.rready), 32'd0);
    checkOutput("reset bready", 32'(axi_req.bready), 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i]);
      creq.valid = 1'b0;
      tick();
    end

    $display("[TB] reset in the middle of a read burst");
    creq.valid    = 1'b1;
    creq.is_write = 1'b0;
    creq.addr     = 32'h2000_0000;
    creq.len      = 4'd3;
    creq.size     = 3'd2;
    creq.burst    = AXI_BURST_INCR;
    tick();
    axi_resp.arready = 1'b1;
    tick();
    axi_resp.arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      axi_resp.rvalid = 1'b1;
      axi_resp.rdata  = 32'h7700_0000 + 32'(b);
      #3;
      checkOutput("pre-reset cresp.ready", 32'(cresp.ready), 32'd1);
      tick();
    end
    axi_resp.rdata = 32'h7700_0002;
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("mid reset cresp.ready", 32'(cresp.ready), 32'd0);
    checkOutput("mid reset cresp.data", cresp.data, 32'd0);
    checkOutput("mid reset rready", 32'(axi_req.rready), 32'd0);
    checkOutput("mid reset arvalid", 32'(axi_req.arvalid), 32'd0);
    axi_resp.rvalid = 1'b0;
    creq.valid      = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    applyStimulus(vecs[0]);
    creq.valid = 1'b0;
    tick();

    $display("[TB] creq.valid held across two reads");
    applyStimulus(vecs[0]);
    applyStimulus(vecs[4]);
    creq.valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
